// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads the program ROM and hands words downstream on a valid/ready handshake.
// Latency: first word is valid two edges after start, then one word per cycle while instr_ready stays high.
// Backpressure: an unaccepted word holds pc/instr/instr_pc and the ROM is simply re-read; jump flushes it.
module instr_fetch #(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_CODE = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] code,
    input  logic              start,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;
    logic   cap;

    // The output register is free when empty or when its word is leaving this cycle.
    assign cap    = !instr_valid || instr_ready;
    assign busy   = (state == FETCH);
    assign halted = (state == HALT) && !instr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (jump_en) begin
                        pc          <= jump_addr;
                        instr_valid <= 1'b0;
                    end else if (cap) begin
                        instr       <= code;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        // The halt word is delivered but the PC parks on it.
                        if (code == HALT_CODE) begin
                            state <= HALT;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (jump_en) begin
                        pc          <= jump_addr;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (start) begin
                        pc          <= RESET_PC;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural program ROM and an expected-word scoreboard.
module tb_instr_fetch;

    typedef struct packed {
        logic [15:0] dat;
        logic [7:0]  adr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pc;
    logic [15:0] code;
    logic        start;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    instr_fetch #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .RESET_PC (8'd0),
        .HALT_CODE(16'hFFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .code       (code),
        .start      (start),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .halted     (halted),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        logic [15:0] w;
        if (a <= 8'd9) w = {8'h00, a} * 16'h1111;
        else if (a == 8'd10) w = 16'hFFFF;
        else w = 16'h0000;
        return w;
    endfunction

    always_comb code = rom_word(pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic [7:0] from_a);
        for (int a = int'(from_a); a <= 10; a++) begin
            sb.push_back('{dat: rom_word(8'(a)), adr: 8'(a)});
        end
    endtask

    task automatic wait_halted(input string tag);
        int n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_word(input string tag, input logic [7:0] a);
        int n = 0;
        while (!(instr_valid && instr_pc == a) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {24'd0, instr_pc}, {24'd0, a});
    endtask

    // Every handshake that completes at the next rising edge must match the queue head.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !jump_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {8'd0, instr_pc, instr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", {16'd0, instr}, {16'd0, e.dat});
                chk("sb_instr_pc", {24'd0, instr_pc}, {24'd0, e.adr});
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = 8'd0;
        instr_ready = 1'b0;
        #12;
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_instr_pc", {24'd0, instr_pc}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_no_fetch", {31'd0, busy}, 32'd0);

        // T1: straight run to the halt word
        instr_ready = 1'b1;
        push_run(8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_valid_n", {31'd0, instr_valid}, 32'd0);
        chk("t1_pc_n", {24'd0, pc}, 32'd0);
        tick();
        chk("t1_valid_n1", {31'd0, instr_valid}, 32'd1);
        chk("t1_first", {16'd0, instr}, 32'h0000);
        wait_halted("t1_halted");
        chk("t1_pc_park", {24'd0, pc}, 32'd10);
        tick();
        chk("t1_pc_stays", {24'd0, pc}, 32'd10);
        chk("t1_sb_empty", sb.size(), 32'd0);

        // T2: backpressure on the 3333 word
        push_run(8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_restart_pc", {24'd0, pc}, 32'd0);
        wait_word("t2_reach3", 8'd3);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_instr", {16'd0, instr}, 32'h3333);
            chk("t2_hold_ipc", {24'd0, instr_pc}, 32'd3);
            chk("t2_hold_pc", {24'd0, pc}, 32'd4);
        end
        instr_ready = 1'b1;
        tick();
        chk("t2_next", {16'd0, instr}, 32'h4444);
        wait_halted("t2_halted");
        chk("t2_sb_empty", sb.size(), 32'd0);

        // T3: jump flushes the stalled 2222 word
        sb.push_back('{dat: 16'h0000, adr: 8'd0});
        sb.push_back('{dat: 16'h1111, adr: 8'd1});
        push_run(8'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_word("t3_reach2", 8'd2);
        instr_ready = 1'b0;
        jump_en     = 1'b1;
        jump_addr   = 8'd7;
        tick();
        jump_en = 1'b0;
        chk("t3_flushed", {31'd0, instr_valid}, 32'd0);
        chk("t3_pc", {24'd0, pc}, 32'd7);
        instr_ready = 1'b1;
        tick();
        chk("t3_instr", {16'd0, instr}, 32'h7777);
        chk("t3_ipc", {24'd0, instr_pc}, 32'd7);
        wait_halted("t3_halted");
        chk("t3_sb_empty", sb.size(), 32'd0);

        // T4: wrap from 255 to 0, then start from halt
        sb.push_back('{dat: 16'h0000, adr: 8'd255});
        push_run(8'd0);
        jump_en   = 1'b1;
        jump_addr = 8'd255;
        tick();
        jump_en = 1'b0;
        chk("t4_pc255", {24'd0, pc}, 32'd255);
        tick();
        chk("t4_ipc255", {24'd0, instr_pc}, 32'd255);
        chk("t4_wrap_pc", {24'd0, pc}, 32'd0);
        tick();
        chk("t4_ipc0", {24'd0, instr_pc}, 32'd0);
        tick();
        chk("t4_instr1", {16'd0, instr}, 32'h1111);
        wait_halted("t4_halted");
        chk("t4_sb_empty", sb.size(), 32'd0);
        push_run(8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart_pc", {24'd0, pc}, 32'd0);
        tick();
        chk("t4_restart_instr", {16'd0, instr}, 32'h0000);
        chk("t4_restart_ipc", {24'd0, instr_pc}, 32'd0);

        // T5: asynchronous reset while a word is valid
        tick();
        chk("t5_pre_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t5_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_pc", {24'd0, pc}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_instr", {16'd0, instr}, 32'd0);
        chk("t5_ipc", {24'd0, instr_pc}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_idle_pc", {24'd0, pc}, 32'd0);
        chk("t5_idle_busy", {31'd0, busy}, 32'd0);
        chk("t5_idle_valid", {31'd0, instr_valid}, 32'd0);

        // T6: start and jump together in IDLE, start wins
        push_run(8'd0);
        start     = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 8'd5;
        tick();
        start   = 1'b0;
        jump_en = 1'b0;
        chk("t6_pc", {24'd0, pc}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t6_instr", {16'd0, instr}, 32'h0000);
        chk("t6_ipc", {24'd0, instr_pc}, 32'd0);
        wait_halted("t6_halted");
        chk("t6_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
